// File: rtl/uart_pkt_rx.sv
// Packet de-framer behind the UART RX FIFO: SOF / length / payload / XOR checksum.
// The payload is buffered and streamed out only after the whole frame checks good.
module uart_pkt_rx #(
  parameter logic [7:0]  Sof     = 8'hA5,
  parameter int unsigned MaxLen  = 16,
  parameter int unsigned Timeout = 2000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [8:0] fifo_dout_i,
  input  logic       fifo_empty_i,
  output logic       fifo_read_o,
  output logic [7:0] pl_data_o,
  output logic       pl_valid_o,
  input  logic       pl_ready_i,
  output logic       pl_last_o,
  output logic       pkt_ok_o,
  output logic       pkt_err_o,
  output logic [1:0] err_code_o
);

  localparam int unsigned PtrW = $clog2(MaxLen + 1);
  localparam int unsigned IdxW = (MaxLen > 1) ? $clog2(MaxLen) : 1;
  localparam int unsigned TmoW = (Timeout > 0) ? $clog2(Timeout + 1) : 1;

  localparam logic [1:0] ErrTmo = 2'd0;
  localparam logic [1:0] ErrPar = 2'd1;
  localparam logic [1:0] ErrLen = 2'd2;
  localparam logic [1:0] ErrChk = 2'd3;

  typedef enum logic [2:0] {StHunt, StLen, StPayload, StChk, StEmit} state_e;

  state_e            state_q, state_d;
  logic              fifo_read_q, fifo_read_d;
  logic              byte_vld_q;
  logic [7:0]        len_q, len_d;
  logic [7:0]        chk_q, chk_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [7:0]        pl_data_q, pl_data_d;
  logic              pl_valid_q, pl_valid_d;
  logic              pl_last_q, pl_last_d;
  logic              pkt_ok_q, pkt_ok_d;
  logic              pkt_err_q, pkt_err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic [7:0]        buf_q [2**IdxW];
  logic              buf_we;

  logic              rx_par;
  logic [7:0]        rx_byte;
  logic              good_byte;
  logic              in_frame;
  logic              err_hit;
  logic [1:0]        err_val;
  logic [PtrW-1:0]   len_p, wr_next, rd_next;

  assign rx_par    = fifo_dout_i[8];
  assign rx_byte   = fifo_dout_i[7:0];
  assign good_byte = byte_vld_q && !rx_par;
  assign in_frame  = (state_q == StLen) || (state_q == StPayload) || (state_q == StChk);
  assign len_p     = PtrW'(len_q);
  assign wr_next   = wr_ptr_q + PtrW'(1);
  assign rd_next   = rd_ptr_q + PtrW'(1);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    chk_d      = chk_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tmo_d      = '0;
    pl_data_d  = pl_data_q;
    pl_valid_d = pl_valid_q;
    pl_last_d  = pl_last_q;
    pkt_ok_d   = 1'b0;
    pkt_err_d  = 1'b0;
    err_code_d = err_code_q;
    buf_we     = 1'b0;
    err_hit    = 1'b0;
    err_val    = ErrTmo;

    // Parity beats everything in-frame; the timeout only counts idle cycles.
    if (in_frame) begin
      if (byte_vld_q && rx_par) begin
        err_hit = 1'b1;
        err_val = ErrPar;
      end else if (!byte_vld_q && Timeout != 0) begin
        tmo_d = tmo_q + TmoW'(1);
        if (32'(tmo_q) + 32'd1 == Timeout) begin
          err_hit = 1'b1;
          err_val = ErrTmo;
        end
      end
    end

    unique case (state_q)
      StHunt: begin
        if (good_byte && rx_byte == Sof) state_d = StLen;
      end
      StLen: begin
        if (good_byte) begin
          len_d = rx_byte;
          chk_d = rx_byte;
          if (32'(rx_byte) > MaxLen) begin
            err_hit = 1'b1;
            err_val = ErrLen;
          end else if (rx_byte == 8'd0) begin
            state_d = StChk;
          end else begin
            state_d  = StPayload;
            wr_ptr_d = '0;
          end
        end
      end
      StPayload: begin
        if (good_byte) begin
          buf_we   = 1'b1;
          chk_d    = chk_q ^ rx_byte;
          wr_ptr_d = wr_next;
          if (wr_next == len_p) state_d = StChk;
        end
      end
      StChk: begin
        if (good_byte) begin
          if (rx_byte == chk_q) begin
            pkt_ok_d = 1'b1;
            if (len_q == 8'd0) begin
              state_d = StHunt;
            end else begin
              state_d  = StEmit;
              rd_ptr_d = '0;
            end
          end else begin
            err_hit = 1'b1;
            err_val = ErrChk;
          end
        end
      end
      StEmit: begin
        if (!pl_valid_q) begin
          pl_valid_d = 1'b1;
          pl_data_d  = buf_q[rd_ptr_q[IdxW-1:0]];
          pl_last_d  = (rd_next == len_p);
        end else if (pl_ready_i) begin
          if (pl_last_q) begin
            pl_valid_d = 1'b0;
            pl_last_d  = 1'b0;
            state_d    = StHunt;
          end else begin
            rd_ptr_d  = rd_next;
            pl_data_d = buf_q[rd_next[IdxW-1:0]];
            pl_last_d = (rd_next + PtrW'(1) == len_p);
          end
        end
      end
      default: state_d = StHunt;
    endcase

    if (err_hit) begin
      state_d    = StHunt;
      pkt_err_d  = 1'b1;
      err_code_d = err_val;
    end

    // One read in flight at most; nothing is fetched while the payload drains.
    fifo_read_d = (state_d != StEmit) && !fifo_empty_i && !fifo_read_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StHunt;
      fifo_read_q <= 1'b0;
      byte_vld_q  <= 1'b0;
      len_q       <= '0;
      chk_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tmo_q       <= '0;
      pl_data_q   <= '0;
      pl_valid_q  <= 1'b0;
      pl_last_q   <= 1'b0;
      pkt_ok_q    <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      fifo_read_q <= fifo_read_d;
      byte_vld_q  <= fifo_read_q;
      len_q       <= len_d;
      chk_q       <= chk_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tmo_q       <= tmo_d;
      pl_data_q   <= pl_data_d;
      pl_valid_q  <= pl_valid_d;
      pl_last_q   <= pl_last_d;
      pkt_ok_q    <= pkt_ok_d;
      pkt_err_q   <= pkt_err_d;
      err_code_q  <= err_code_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (buf_we) buf_q[wr_ptr_q[IdxW-1:0]] <= rx_byte;
  end

  assign fifo_read_o = fifo_read_q;
  assign pl_data_o   = pl_data_q;
  assign pl_valid_o  = pl_valid_q;
  assign pl_last_o   = pl_last_q;
  assign pkt_ok_o    = pkt_ok_q;
  assign pkt_err_o   = pkt_err_q;
  assign err_code_o  = err_code_q;

endmodule
